// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Sequential unsigned restoring divider. A start pulse captures a
// dividend/divisor pair. The block then produces one quotient bit per clock,
// MSB first. It reports quotient and remainder together with a one-cycle done
// pulse.
//
// Parameters:
//   DIVIDEND_W  dividend / quotient width (>= 2)
//   DIVISOR_W   divisor / remainder width (1 <= DIVISOR_W <= DIVIDEND_W)
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only when not busy
//   dividend     in   unsigned dividend, captured on the accepted start edge
//   divisor      in   unsigned divisor, captured on the accepted start edge
//   busy         out  high while a division is running
//   done         out  one-cycle pulse, results valid
//   quotient     out  result, held until the next accepted start
//   remainder    out  result, held until the next accepted start
//   div_by_zero  out  set with done when the divisor was zero
//
// Optional feature macro: SEQ_DIVIDER_ZERO_CHECK_EN
//   Defined   : a zero divisor skips the iterations and finishes at once,
//               with div_by_zero raised.
//   Undefined : a zero divisor runs the full latency, and div_by_zero is tied 0.
//   In both builds a zero divisor yields an all-ones quotient and
//   remainder = dividend[DIVISOR_W-1:0].
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int               CNT_W    = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  // work_reg starts out holding the dividend. Each iteration shifts the
  // dividend out at the top and the new quotient bit in at the bottom. After
  // DIVIDEND_W iterations, work_reg holds the complete quotient.
  logic [DIVIDEND_W-1:0] work_reg;
  logic [DIVISOR_W-1:0]  dvsr_reg;
  logic [DIVISOR_W:0]    rem_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DIVIDEND_W-1:0] quot_reg;
  logic [DIVISOR_W-1:0]  remd_reg;

  logic                  accept;
  logic                  last;
  logic                  zero_req;
  logic [DIVISOR_W:0]    shifted;
  logic                  fits;
  logic [DIVISOR_W:0]    step;

  assign accept = start && (state_reg != RUN);

  // In RUN, the counter reaches DIVIDEND_W after the last iteration. The
  // following edge only registers the results and moves the FSM to DONE.
  assign last = (cnt_reg == LAST_CNT);

  // One restoring step. The partial remainder is always below the divisor
  // before the shift, so one extra bit is enough to hold the shifted value.
  assign shifted = {rem_reg[DIVISOR_W-1:0], work_reg[DIVIDEND_W-1]};
  assign fits    = (shifted >= {1'b0, dvsr_reg});
  assign step    = fits ? (shifted - {1'b0, dvsr_reg}) : shifted;

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  assign zero_req = accept && (divisor == '0);
`else
  assign zero_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          state_next = zero_req ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  logic dbz_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_reg <= '0;
      dvsr_reg <= '0;
      rem_reg  <= '0;
      cnt_reg  <= '0;
      quot_reg <= '0;
      remd_reg <= '0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      dbz_reg  <= 1'b0;
`endif
    end else if (accept) begin
      work_reg <= dividend;
      dvsr_reg <= divisor;
      rem_reg  <= '0;
      cnt_reg  <= '0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      // Clears on any accepted start and is set only by the zero shortcut.
      // The shortcut enters DONE directly, so the results load here too.
      dbz_reg <= zero_req;
      if (zero_req) begin
        quot_reg <= '1;
        remd_reg <= dividend[DIVISOR_W-1:0];
      end
`endif
    end else if (state_reg == RUN) begin
      if (last) begin
        quot_reg <= work_reg;
        remd_reg <= rem_reg[DIVISOR_W-1:0];
      end else begin
        rem_reg  <= step;
        work_reg <= {work_reg[DIVIDEND_W-2:0], fits};
        cnt_reg  <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign quotient  = quot_reg;
  assign remainder = remd_reg;

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Scoreboard bench for seq_divider with default parameters (8 / 4).
// Each accepted start pushes its expected quotient, remainder, div_by_zero and
// done latency. A negedge monitor pops one entry per done pulse and compares.
// Expected values come from constants or from plain integer / and %.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    int            lat;  // edges from the accepting edge E0 to the edge that enters DONE
    longint        t;    // negedge time at which start was raised
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // Raise start at a negedge and record what the division must return.
  // The task returns at the following negedge, after the accepting edge.
  task automatic issue_exp(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input logic [DW-1:0] q, input logic [VW-1:0] r);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = ZC && (b == '0);
    e.lat = (ZC && (b == '0)) ? 0 : DW + 1;
    e.t   = longint'($time);
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("issue %0d / %0d -> expect q=%0d r=%0d", a, b, q, r);
  endtask

  // Reference: ordinary integer division, with the zero-divisor rule.
  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a[VW-1:0];
    end else begin
      q = DW'(int'(a) / int'(b));
      r = VW'(int'(a) % int'(b));
    end
    issue_exp(a, b, q, r);
  endtask

  // Return at the negedge where done is seen. Give up after a bounded wait.
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      @(negedge clk);
    end
    chk("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none pending at t=%0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("done q=%0d r=%0d dbz=%0d (expect %0d %0d %0d)",
                 quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("latency", (longint'($time) - e.t) / 10 - 1, e.lat);
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic divide, with the busy/done timeline checked cycle by cycle.
    issue_exp(8'd225, 4'd15, 8'd15, 4'd0);
    chk("busy_after_e0", busy, 1);
    chk("done_after_e0", done, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    repeat (2) @(negedge clk);

    // Value sweep.
    issue_exp(8'd200, 4'd7, 8'd28, 4'd4);  wait_done();
    issue_exp(8'd7,   4'd9, 8'd0,  4'd7);  wait_done();
    issue_exp(8'd255, 4'd1, 8'd255, 4'd0); wait_done();
    issue_exp(8'd0,   4'd5, 8'd0,  4'd0);  wait_done();
    @(negedge clk);

    // Back-to-back. The second start is raised during the done cycle.
    issue_exp(8'd100, 4'd3, 8'd33, 4'd1);
    wait_done();
    issue_exp(8'd50, 4'd5, 8'd10, 4'd0);
    wait_done();
    repeat (3) @(negedge clk);

    // A start pulse in mid-run is ignored. Operands may change freely.
    issue_exp(8'd200, 4'd7, 8'd28, 4'd4);
    repeat (3) @(negedge clk);
    dividend = 8'd99;
    divisor  = 4'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);

    // Reset near iteration 4. The outputs clear at once and no done follows.
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue_exp(8'd200, 4'd7, 8'd28, 4'd4);
    wait_done();
    @(negedge clk);

    // Divide by zero.
    issue_exp(8'd100, 4'd0, 8'd255, 4'd4);
    wait_done();
    @(negedge clk);
    issue_exp(8'd17, 4'd4, 8'd4, 4'd1);
    wait_done();
    @(negedge clk);

    // Cross-check against multiplier products.
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        issue_exp(DW'(a * b), VW'(b), DW'(a), 4'd0);
        wait_done();
      end
    end
    @(negedge clk);

    // Random operands and random gaps, including zero divisors and
    // back-to-back starts.
    for (int n = 0; n < 150; n++) begin
      logic [DW-1:0] ra;
      logic [VW-1:0] rb;
      ra = DW'($urandom_range(0, 255));
      rb = VW'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ra, rb);
      wait_done();
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
